// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, saturation bounds and pipeline tag type for the MAC.
package mac_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_ACC_W = 16;
  localparam int DEF_MUL_STAGES = 1;
  typedef struct packed {
    logic vld;
    logic clr;
  } tag_t;
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_mul_pipe.sv
// mac_mul_pipe: signed IN_W x IN_W multiplier with MUL_STAGES output registers; tag rides alongside.
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   i_a,
  input  logic signed [IN_W-1:0]   i_b,
  input  tag_t                     i_tag,
  output logic signed [2*IN_W-1:0] o_p,
  output tag_t                     o_tag
);
  logic signed [2*IN_W-1:0] r_p [MUL_STAGES];
  tag_t r_tag [MUL_STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_p[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_p[0] <= (2*IN_W)'(i_a) * (2*IN_W)'(i_b);
      r_tag[0] <= i_tag;
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_p[i] <= r_p[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end
  assign o_p = r_p[MUL_STAGES-1];
  assign o_tag = r_tag[MUL_STAGES-1];
endmodule

// File: rtl/mac_pipe_param.sv
// mac_pipe_param: pipelined signed MAC with per-sample clear and sticky overflow.
// Define MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_pipe_param
  import mac_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  input  logic                    clear_in,
  output logic                    valid_out,
  output logic signed [ACC_W-1:0] f,
  output logic                    ovf
);
  if (ACC_W < 2*IN_W) begin : g_acc_w_chk
    $error("mac_pipe_param: ACC_W must be >= 2*IN_W");
  end
  if (MUL_STAGES < 1) begin : g_stage_chk
    $error("mac_pipe_param: MUL_STAGES must be >= 1");
  end
  logic signed [IN_W-1:0] r_a, r_b;
  tag_t r_tag, w_tag;
  logic signed [2*IN_W-1:0] w_p;
  logic signed [ACC_W-1:0] w_ext, w_next, r_f;
  logic signed [ACC_W:0] w_sum;
  logic w_ovf, r_vo, r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_tag <= '0;
    end else begin
      r_a <= a;
      r_b <= b;
      r_tag <= '{vld: valid_in, clr: clear_in & valid_in};
    end
  end
  mac_mul_pipe #(.IN_W(IN_W), .MUL_STAGES(MUL_STAGES)) u_mul (
    .clk(clk),
    .reset(reset),
    .i_a(r_a),
    .i_b(r_b),
    .i_tag(r_tag),
    .o_p(w_p),
    .o_tag(w_tag)
  );
  // One extra sum bit exposes signed overflow as a mismatch of the top two bits.
  assign w_ext = ACC_W'(w_p);
  assign w_sum = (ACC_W+1)'(r_f) + (ACC_W+1)'(w_ext);
  assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(sat_min(ACC_W));
  assign w_next = w_ovf ? (w_sum[ACC_W] ? SMIN : SMAX) : w_sum[ACC_W-1:0];
`else
  assign w_next = w_sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f <= '0;
      r_vo <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_vo <= w_tag.vld;
      if (w_tag.vld) begin
        r_f <= w_tag.clr ? w_ext : w_next;
        r_ovf <= w_tag.clr ? 1'b0 : (r_ovf | w_ovf);
      end
    end
  end
  assign f = r_f;
  assign valid_out = r_vo;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_mac_pipe_param.sv
// tb_mac_pipe_param: directed table-driven bench for the MAC, plus reset, latency and deep-pipe sequences.
module tb_mac_pipe_param;
  logic clk = 1'b0;
  logic reset;
  logic signed [7:0] a, b, a3, b3;
  logic v, c, v3, c3;
  logic vo, vo3, ovf, ovf3;
  logic signed [15:0] f, f3;
  int checks = 0;
  int errors = 0;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    int a;
    int b;
    bit v;
    bit c;
    bit vo;
    int f;
    bit ovf;
  } vec_t;
  vec_t tv[20];

  always #5 clk = ~clk;

  mac_pipe_param u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(v), .clear_in(c),
    .valid_out(vo), .f(f), .ovf(ovf)
  );
  mac_pipe_param #(.MUL_STAGES(3)) u_dut3 (
    .clk(clk), .reset(reset), .a(a3), .b(b3), .valid_in(v3), .clear_in(c3),
    .valid_out(vo3), .f(f3), .ovf(ovf3)
  );

  task automatic chk(input string n, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int aa, input int bb, input bit vv, input bit cc);
    a = 8'(aa);
    b = 8'(bb);
    v = vv;
    c = cc;
  endtask

  task automatic chk_out(input string n, input bit evo, input int ef, input bit eovf);
    chk({n, " valid_out"}, vo, evo);
    chk({n, " f"}, f, ef);
    chk({n, " ovf"}, ovf, eovf);
  endtask

  initial begin
    tv[0]  = '{3, 4, 1, 1, 1, 12, 0};
    tv[1]  = '{-2, 5, 1, 0, 1, 2, 0};
    tv[2]  = '{10, -10, 1, 0, 1, -98, 0};
    tv[3]  = '{1, 1, 1, 1, 1, 1, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 1, 0};
    tv[5]  = '{2, 2, 1, 0, 1, 5, 0};
    tv[6]  = '{9, 9, 0, 1, 0, 5, 0};
    tv[7]  = '{1, 3, 1, 0, 1, 8, 0};
    tv[8]  = '{127, 127, 1, 1, 1, 16129, 0};
    tv[9]  = '{127, 127, 1, 0, 1, 32258, 0};
    tv[10] = '{127, 127, 1, 0, 1, SAT ? 32767 : -17149, 1};
    tv[11] = '{0, 0, 0, 0, 0, SAT ? 32767 : -17149, 1};
    tv[12] = '{0, 0, 1, 1, 1, 0, 0};
    tv[13] = '{-128, -128, 1, 1, 1, 16384, 0};
    tv[14] = '{-128, -128, 1, 0, 1, SAT ? 32767 : -32768, 1};
    tv[15] = '{-1, 1, 1, 0, 1, SAT ? 32766 : 32767, 1};
    tv[16] = '{-128, 127, 1, 1, 1, -16256, 0};
    tv[17] = '{-128, 127, 1, 0, 1, -32512, 0};
    tv[18] = '{-128, 127, 1, 0, 1, SAT ? -32768 : 16768, 1};
    tv[19] = '{2, 3, 1, 0, 1, SAT ? -32762 : 16774, 1};

    reset = 1'b1;
    drive(0, 0, 0, 0);
    a3 = 0; b3 = 0; v3 = 0; c3 = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("reset%0d", i), 0, 0, 0);
      chk($sformatf("reset%0d valid_out3", i), vo3, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 0, 0, 0);
    end
    drive(3, 4, 1, 1);
    tick();
    chk("lat edge1 valid_out", vo, 0);
    drive(0, 0, 0, 0);
    tick();
    chk("lat edge2 valid_out", vo, 0);
    tick();
    chk_out("lat edge3", 1, 12, 0);
    tick();
    chk_out("lat edge4", 0, 12, 0);

    for (int i = 0; i < 22; i++) begin
      if (i < 20) drive(tv[i].a, tv[i].b, tv[i].v, tv[i].c);
      else drive(0, 0, 0, 0);
      tick();
      if (i >= 2) chk_out($sformatf("row%0d", i - 2), tv[i-2].vo, tv[i-2].f, tv[i-2].ovf);
    end

    drive(5, 5, 1, 1);
    tick();
    drive(6, 6, 1, 0);
    tick();
    drive(7, 7, 1, 0);
    reset = 1'b1;
    tick();
    chk_out("midreset", 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("postreset%0d", i), 0, 0, 0);
    end

    a3 = 5; b3 = 6; v3 = 1; c3 = 1;
    tick();
    chk("deep edge1 valid_out", vo3, 0);
    a3 = 0; b3 = 0; v3 = 0; c3 = 0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("deep edge%0d valid_out", k), vo3, 0);
    end
    tick();
    chk("deep edge5 valid_out", vo3, 1);
    chk("deep edge5 f", f3, 30);
    chk("deep edge5 ovf", ovf3, 0);
    tick();
    chk("deep edge6 valid_out", vo3, 0);
    chk("deep edge6 f", f3, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
